// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing and pixel-output stage.
//
// Runs on vga_clock, the only clock of the block. It walks an h/v raster,
// asks the frame/line store for each visible pixel by coordinate, and
// registers the returned RGB332 pixel onto the VGA pins. Blanking always
// drives black.
//
// Pipeline:
//   stage 0  counters -> pixel_request/pixel_x/pixel_y (combinational)
//   stage 1  source returns pixel_data one cycle later; control delayed 1
//   stage 2  pins registered; colour, syncs and start pulses line up here
// The counter-to-pin latency is a fixed 2 clocks, with no stalls.
//
// Ports:
//   vga_clock, reset_n     pixel clock, asynchronous active-low reset
//   enable                 raster run; low holds the counters at (0,0)
//   pixel_request          stage-0 coordinate is visible
//   pixel_x, pixel_y       requested coordinate, 0 when not requesting
//   pixel_data             {R,G,B} for the previous cycle's request
//   vga_hsync, vga_vsync   sync pins (level set by HSYNC_ACTIVE/VSYNC_ACTIVE)
//   vga_red/green/blue     colour pins
//   line_start             pins carry h=0 of a line (one cycle)
//   frame_start            pins carry (0,0) (one cycle)
//   dbg_h_phase            horizontal phase: 0 active, 1 front, 2 sync, 3 back
//   dbg_v_phase            vertical phase, same encoding
//
// Optional feature, macro VGA_TEST_PATTERN_EN: adds input test_pattern. When
// it is high, visible pixels come from 8 vertical colour bars, selected by
// x[9:7], instead of pixel_data, and pixel_request stays low.
//
// Handshake: there is no valid/ready. A source that sees pixel_request high
// in cycle n must present that pixel on pixel_data throughout cycle n+1. It
// cannot stall the raster.

module vga_timing_gen #(
  parameter int   H_VISIBLE      = 640,
  parameter int   H_FRONT        = 16,
  parameter int   H_SYNC         = 96,
  parameter int   H_BACK         = 48,
  parameter int   V_VISIBLE      = 480,
  parameter int   V_FRONT        = 10,
  parameter int   V_SYNC         = 2,
  parameter int   V_BACK         = 33,
  parameter logic HSYNC_ACTIVE   = 1'b0,
  parameter logic VSYNC_ACTIVE   = 1'b0,
  parameter int   COUNTER_BITS   = 10,
  parameter int   VGA_RED_BITS   = 3,
  parameter int   VGA_GREEN_BITS = 3,
  parameter int   VGA_BLUE_BITS  = 2
) (
  input  logic                    vga_clock,
  input  logic                    reset_n,
  input  logic                    enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                    test_pattern,
`endif
  output logic                    pixel_request,
  output logic [COUNTER_BITS-1:0] pixel_x,
  output logic [COUNTER_BITS-1:0] pixel_y,
  input  logic [VGA_RED_BITS+VGA_GREEN_BITS+VGA_BLUE_BITS-1:0] pixel_data,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [VGA_RED_BITS-1:0]   vga_red,
  output logic [VGA_GREEN_BITS-1:0] vga_green,
  output logic [VGA_BLUE_BITS-1:0]  vga_blue,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [1:0]              dbg_h_phase,
  output logic [1:0]              dbg_v_phase
);

  localparam int PIXEL_BITS = VGA_RED_BITS + VGA_GREEN_BITS + VGA_BLUE_BITS;
  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; a phase is left when its last count is reached.
  localparam logic [COUNTER_BITS-1:0] H_ACT_LAST   = COUNTER_BITS'(H_VISIBLE - 1);
  localparam logic [COUNTER_BITS-1:0] H_FRONT_LAST = COUNTER_BITS'(H_VISIBLE + H_FRONT - 1);
  localparam logic [COUNTER_BITS-1:0] H_SYNC_LAST  = COUNTER_BITS'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNTER_BITS-1:0] H_LAST       = COUNTER_BITS'(H_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] V_ACT_LAST   = COUNTER_BITS'(V_VISIBLE - 1);
  localparam logic [COUNTER_BITS-1:0] V_FRONT_LAST = COUNTER_BITS'(V_VISIBLE + V_FRONT - 1);
  localparam logic [COUNTER_BITS-1:0] V_SYNC_LAST  = COUNTER_BITS'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [COUNTER_BITS-1:0] V_LAST       = COUNTER_BITS'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic [COUNTER_BITS-1:0] h_count, h_count_next;
  logic [COUNTER_BITS-1:0] v_count, v_count_next;
  phase_t                  h_state, h_state_next;
  phase_t                  v_state, v_state_next;
  logic                    h_wrap;

  // Stage 0, derived from the counters.
  logic run_s0;
  logic vis_s0;
  logic hsync_on_s0;
  logic vsync_on_s0;
  logic line_s0;
  logic frame_s0;
  logic tp_s0;

  // Stage 1 registers.
  logic       vis_s1;
  logic       hsync_on_s1;
  logic       vsync_on_s1;
  logic       line_s1;
  logic       frame_s1;
  logic [PIXEL_BITS-1:0] pix_sel;

`ifdef VGA_TEST_PATTERN_EN
  logic       tp_s1;
  logic [2:0] bar_s1;
`endif

  // ---------------------------------------------------------------------
  // Raster counters and phase FSMs: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_count <= h_count_next;
      v_count <= v_count_next;
      h_state <= h_state_next;
      v_state <= v_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. Dropping enable parks the raster at (0,0), which is
  // the start of an ACTIVE/ACTIVE position, so restart needs no extra state.
  // ---------------------------------------------------------------------
  always_comb begin
    h_wrap       = (h_count == H_LAST);
    h_count_next = h_count + COUNTER_BITS'(1);
    v_count_next = v_count;
    h_state_next = h_state;
    v_state_next = v_state;

    if (!enable) begin
      h_count_next = '0;
      v_count_next = '0;
      h_state_next = PH_ACTIVE;
      v_state_next = PH_ACTIVE;
    end else begin
      if (h_wrap) begin
        h_count_next = '0;
        v_count_next = (v_count == V_LAST) ? '0 : v_count + COUNTER_BITS'(1);
      end

      case (h_state)
        PH_ACTIVE: if (h_count == H_ACT_LAST)   h_state_next = PH_FRONT;
        PH_FRONT:  if (h_count == H_FRONT_LAST) h_state_next = PH_SYNC;
        PH_SYNC:   if (h_count == H_SYNC_LAST)  h_state_next = PH_BACK;
        PH_BACK:   if (h_wrap)                  h_state_next = PH_ACTIVE;
        default:                                h_state_next = PH_ACTIVE;
      endcase

      // The vertical FSM only moves on the last clock of a line.
      if (h_wrap) begin
        case (v_state)
          PH_ACTIVE: if (v_count == V_ACT_LAST)   v_state_next = PH_FRONT;
          PH_FRONT:  if (v_count == V_FRONT_LAST) v_state_next = PH_SYNC;
          PH_SYNC:   if (v_count == V_SYNC_LAST)  v_state_next = PH_BACK;
          PH_BACK:   if (v_count == V_LAST)       v_state_next = PH_ACTIVE;
          default:                                v_state_next = PH_ACTIVE;
        endcase
      end
    end
  end

  assign dbg_h_phase = h_state;
  assign dbg_v_phase = v_state;

  // ---------------------------------------------------------------------
  // Stage 0. reset_n is folded into run_s0 so the combinational request
  // outputs are also quiet while reset is held, even if enable is high.
  // ---------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
  assign tp_s0 = test_pattern;
`else
  assign tp_s0 = 1'b0;
`endif

  always_comb begin
    run_s0      = enable & reset_n;
    vis_s0      = run_s0 & (h_state == PH_ACTIVE) & (v_state == PH_ACTIVE);
    hsync_on_s0 = run_s0 & (h_state == PH_SYNC);
    vsync_on_s0 = run_s0 & (v_state == PH_SYNC);
    line_s0     = run_s0 & (h_count == '0);
    frame_s0    = line_s0 & (v_count == '0);

    pixel_request = vis_s0 & ~tp_s0;
    pixel_x       = pixel_request ? h_count : '0;
    pixel_y       = pixel_request ? v_count : '0;
  end

  // ---------------------------------------------------------------------
  // Stage 1: control delayed to meet the pixel returned by the source.
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      vis_s1      <= 1'b0;
      hsync_on_s1 <= 1'b0;
      vsync_on_s1 <= 1'b0;
      line_s1     <= 1'b0;
      frame_s1    <= 1'b0;
    end else begin
      vis_s1      <= vis_s0;
      hsync_on_s1 <= hsync_on_s0;
      vsync_on_s1 <= vsync_on_s0;
      line_s1     <= line_s0;
      frame_s1    <= frame_s0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      tp_s1  <= 1'b0;
      bar_s1 <= '0;
    end else begin
      tp_s1  <= tp_s0;
      bar_s1 <= h_count[9:7];
    end
  end
`endif

  // Pixel selection. Blanking is forced black whatever the source returned.
  always_comb begin
    pix_sel = pixel_data;
`ifdef VGA_TEST_PATTERN_EN
    if (tp_s1) begin
      pix_sel = {{VGA_RED_BITS{bar_s1[2]}},
                 {VGA_GREEN_BITS{bar_s1[1]}},
                 {VGA_BLUE_BITS{bar_s1[0]}}};
    end
`endif
    if (!vis_s1) begin
      pix_sel = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: output pins.
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync   <= ~HSYNC_ACTIVE;
      vga_vsync   <= ~VSYNC_ACTIVE;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= hsync_on_s1 ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vga_vsync   <= vsync_on_s1 ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      vga_red     <= pix_sel[PIXEL_BITS-1 -: VGA_RED_BITS];
      vga_green   <= pix_sel[VGA_GREEN_BITS+VGA_BLUE_BITS-1 -: VGA_GREEN_BITS];
      vga_blue    <= pix_sel[VGA_BLUE_BITS-1:0];
      line_start  <= line_s1;
      frame_start <= frame_s1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
//
// Horizontal timing is the full 640/16/96/48. The vertical phases are cut to
// 32/2/2/3 lines so that whole frames fit in a short run. The 2-line vsync
// still gives a 1600-clock pulse.
//
// Each cycle, step() drives the inputs 1 time unit after the rising edge and
// samples 1 unit later. The bench model predicts the stage-0 request and
// coordinate and checks them at once. It also predicts the pin word for the
// same cycle, pushes that word onto exp_q, and pops it when the pins show it
// 2 cycles later. The bench also plays the frame store: it answers each
// request with a byte on the next cycle. (0,0) always gets 8'hE3, h=640
// always gets 8'hFF, and every other coordinate gets a random byte.

module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 32, VF = 2, VS = 2, VB = 3;
  localparam int VT = VV + VF + VS + VB;
  // pin word: {hsync, vsync, line_start, frame_start, red, green, blue}
  localparam logic [11:0] IDLE_PINS = 12'hC00;

  // ---------------- clock / reset ----------------
  logic       vga_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;
  logic [7:0] pixel_data = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_pattern = 1'b0;
`endif
  logic       pixel_request;
  logic [9:0] pixel_x, pixel_y;
  logic       vga_hsync, vga_vsync;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;
  logic       line_start, frame_start;
  logic [1:0] dbg_h_phase, dbg_v_phase;

  always #5 vga_clock = ~vga_clock;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .vga_clock     (vga_clock),
    .reset_n       (reset_n),
    .enable        (enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern  (test_pattern),
`endif
    .pixel_request (pixel_request),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_data    (pixel_data),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_red       (vga_red),
    .vga_green     (vga_green),
    .vga_blue      (vga_blue),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .dbg_h_phase   (dbg_h_phase),
    .dbg_v_phase   (dbg_v_phase)
  );

  // ---------------- bench state ----------------
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          mh = 0, mv = 0;
  logic        en_cmd = 1'b0;
  logic        tp_cmd = 1'b0;
  logic [7:0]  drive_data = 8'h00;
  logic [11:0] exp_q[$];
  int          fs_first = -1;

  // ---------------- driver + scoreboard, one clock ----------------
  task automatic step();
    logic        vis, ereq, hs, vs, ls, fs;
    logic [7:0]  d, col;
    logic [2:0]  bar;
    logic [11:0] exp_pins, got_pins;
    logic [20:0] exp_s0, got_s0;
    @(posedge vga_clock);
    #1;
    enable = en_cmd;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = tp_cmd;
`endif
    pixel_data = drive_data;
    #1;
    vis  = en_cmd && (mh < HV) && (mv < VV);
    ereq = vis && !tp_cmd;
    exp_s0 = {ereq, ereq ? 10'(mh) : 10'd0, ereq ? 10'(mv) : 10'd0};
    got_s0 = {pixel_request, pixel_x, pixel_y};
    checks++;
    if (got_s0 !== exp_s0)
      $display("FAIL stage0 cyc=%0d got req=%0b x=%0d y=%0d expected req=%0b x=%0d y=%0d",
               cyc, pixel_request, pixel_x, pixel_y, ereq, exp_s0[19:10], exp_s0[9:0]);
    else passes++;

    got_pins = {vga_hsync, vga_vsync, line_start, frame_start, vga_red, vga_green, vga_blue};
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL pins cyc=%0d got %h expected queue entry (queue empty)", cyc, got_pins);
    end else begin
      exp_pins = exp_q.pop_front();
      if (got_pins !== exp_pins)
        $display("FAIL pins cyc=%0d got %h expected %h", cyc, got_pins, exp_pins);
      else passes++;
    end

    if (mh == 0 && mv == 0) d = 8'hE3;
    else if (mh == HV)      d = 8'hFF;
    else                    d = 8'($urandom_range(0, 255));
    drive_data = d;

    bar = 3'(mh >> 7);
    if (!vis)        col = 8'h00;
    else if (tp_cmd) col = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
    else             col = d;
    hs = !(en_cmd && mh >= HV + HF && mh < HV + HF + HS);
    vs = !(en_cmd && mv >= VV + VF && mv < VV + VF + VS);
    ls = en_cmd && (mh == 0);
    fs = ls && (mv == 0);
    exp_q.push_back({hs, vs, ls, fs, col});

    if (!en_cmd) begin
      mh = 0; mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    cyc++;
  endtask

  task automatic release_reset();
    @(posedge vga_clock);
    #1;
    reset_n = 1'b1;
    mh = 0; mv = 0;
    drive_data = 8'h00;
    exp_q.delete();
    exp_q.push_back(IDLE_PINS);
    exp_q.push_back(IDLE_PINS);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; en_cmd = 1'b0; enable = 1'b0;
    repeat (3) @(posedge vga_clock);
    #2;
    checks++;
    if ({vga_hsync, vga_vsync, line_start, frame_start, vga_red, vga_green, vga_blue} !== IDLE_PINS)
      $display("FAIL reset_pins got hs=%0b vs=%0b ls=%0b fs=%0b rgb=%h/%h/%h expected idle",
               vga_hsync, vga_vsync, line_start, frame_start, vga_red, vga_green, vga_blue);
    else passes++;
    checks++;
    if ({pixel_request, pixel_x, pixel_y} !== 21'd0)
      $display("FAIL reset_request got req=%0b x=%0d y=%0d expected 0/0/0",
               pixel_request, pixel_x, pixel_y);
    else passes++;
    release_reset();
    repeat (6) step();
    checks++;
    if ({vga_hsync, vga_vsync, pixel_request} !== 3'b110)
      $display("FAIL idle_hold got hs=%0b vs=%0b req=%0b expected 1 1 0",
               vga_hsync, vga_vsync, pixel_request);
    else passes++;
  endtask

  task automatic test_line_timing();
    int t0, obs;
    int hs_fall = -1, hs_low = 0, ls_first = -1, ls_second = -1;
    int prev_x = -1, prev_y = -1, prev_t = -1;
    bit seen_next_line = 1'b0;
    logic hs_prev = 1'b1;
    en_cmd = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 1700; i++) begin
      step();
      obs = cyc - 1;
      if (frame_start && fs_first < 0) begin
        fs_first = obs;
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 8'hE3)
          $display("FAIL first_pixel got r=%0d g=%0d b=%0d expected 7 0 3",
                   vga_red, vga_green, vga_blue);
        else passes++;
      end
      if (line_start) begin
        if (ls_first < 0) ls_first = obs;
        else if (ls_second < 0) ls_second = obs;
      end
      if (obs < t0 + HT) begin
        if (!vga_hsync) hs_low++;
        if (!vga_hsync && hs_prev && hs_fall < 0) hs_fall = obs;
      end
      hs_prev = vga_hsync;
      if (obs == t0 + HV + 2) begin
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 8'h00)
          $display("FAIL blank_ignores_ff got %h expected 00", {vga_red, vga_green, vga_blue});
        else passes++;
      end
      if (pixel_request) begin
        if (pixel_x == 10'd0 && pixel_y == 10'd1 && !seen_next_line) begin
          seen_next_line = 1'b1;
          checks++;
          if (prev_x != HV - 1 || prev_y != 0 || obs - prev_t != HT - HV + 1)
            $display("FAIL line_gap got prev=(%0d,%0d) gap=%0d expected (639,0) gap=%0d",
                     prev_x, prev_y, obs - prev_t, HT - HV + 1);
          else passes++;
        end
        prev_x = pixel_x; prev_y = pixel_y; prev_t = obs;
      end
    end
    checks++;
    if (fs_first != t0 + 2)
      $display("FAIL frame_start_latency got %0d expected %0d", fs_first - t0, 2);
    else passes++;
    checks++;
    if (hs_fall != t0 + HV + HF + 2)
      $display("FAIL hsync_start got %0d expected %0d", hs_fall - t0, HV + HF + 2);
    else passes++;
    checks++;
    if (hs_low != HS) $display("FAIL hsync_width got %0d expected %0d", hs_low, HS);
    else passes++;
    checks++;
    if (ls_second - ls_first != HT)
      $display("FAIL line_period got %0d expected %0d", ls_second - ls_first, HT);
    else passes++;
    checks++;
    if (!seen_next_line) $display("FAIL next_line_request got none expected (0,1)");
    else passes++;
  endtask

  task automatic test_frame();
    int obs, vs_low = 0, last_x = -1, last_y = -1, wrap_t = -1, fs2 = -1;
    for (int i = 0; i < HT * VT + 10 && fs2 < 0; i++) begin
      step();
      obs = cyc - 1;
      if (!vga_vsync) vs_low++;
      if (pixel_request) begin
        if (pixel_x == 10'd0 && pixel_y == 10'd0 && wrap_t < 0) begin
          wrap_t = obs;
          checks++;
          if (last_x != HV - 1 || last_y != VV - 1)
            $display("FAIL last_request got (%0d,%0d) expected (%0d,%0d)",
                     last_x, last_y, HV - 1, VV - 1);
          else passes++;
        end
        last_x = pixel_x; last_y = pixel_y;
      end
      if (frame_start) fs2 = obs;
    end
    checks++;
    if (wrap_t < 0 || fs2 != wrap_t + 2)
      $display("FAIL frame_wrap got fs=%0d req00=%0d expected fs=req00+2", fs2, wrap_t);
    else passes++;
    checks++;
    if (fs2 - fs_first != HT * VT)
      $display("FAIL frame_period got %0d expected %0d", fs2 - fs_first, HT * VT);
    else passes++;
    checks++;
    if (vs_low != VS * HT) $display("FAIL vsync_width got %0d expected %0d", vs_low, VS * HT);
    else passes++;
  endtask

  task automatic test_enable_drop();
    int t_fall, t_rise;
    bit reached = 1'b0;
    for (int i = 0; i < HT * VT && !reached; i++) begin
      if (mh == 300 && mv == 20) reached = 1'b1;
      else step();
    end
    checks++;
    if (!reached) $display("FAIL reach_300_20 got (%0d,%0d) expected (300,20)", mh, mv);
    else passes++;
    en_cmd = 1'b0;
    step();
    t_fall = cyc - 1;
    step();
    step();
    checks++;
    if ({vga_hsync, vga_vsync, vga_red, vga_green, vga_blue} !== 10'h300 || cyc - 1 != t_fall + 2)
      $display("FAIL drop_idle got hs=%0b vs=%0b rgb=%h expected idle 2 clocks after fall",
               vga_hsync, vga_vsync, {vga_red, vga_green, vga_blue});
    else passes++;
    repeat (8) step();
    en_cmd = 1'b1;
    t_rise = cyc;
    step();
    checks++;
    if ({pixel_request, pixel_x, pixel_y} !== {1'b1, 20'd0} || frame_start !== 1'b0)
      $display("FAIL restart_request got req=%0b x=%0d y=%0d fs=%0b expected 1 0 0 fs=0",
               pixel_request, pixel_x, pixel_y, frame_start);
    else passes++;
    step();
    step();
    checks++;
    if (frame_start !== 1'b1 || cyc - 1 != t_rise + 2)
      $display("FAIL restart_frame_start got %0b expected 1 two clocks after rise", frame_start);
    else passes++;
  endtask

  task automatic test_reset_in_sync();
    bit reached = 1'b0;
    for (int i = 0; i < HT * VT && !reached; i++) begin
      if (mh == 700 && mv == VV + VF + VS - 1) reached = 1'b1;
      else step();
    end
    step();
    checks++;
    if (!reached || vga_hsync !== 1'b0 || vga_vsync !== 1'b0)
      $display("FAIL in_sync got reached=%0b hs=%0b vs=%0b expected 1 0 0",
               reached, vga_hsync, vga_vsync);
    else passes++;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({vga_hsync, vga_vsync, line_start, frame_start, vga_red, vga_green, vga_blue} !== IDLE_PINS)
      $display("FAIL reset_async got hs=%0b vs=%0b rgb=%h expected idle",
               vga_hsync, vga_vsync, {vga_red, vga_green, vga_blue});
    else passes++;
    checks++;
    if ({pixel_request, pixel_x, pixel_y} !== 21'd0)
      $display("FAIL reset_request_en_high got req=%0b x=%0d y=%0d expected 0 0 0",
               pixel_request, pixel_x, pixel_y);
    else passes++;
    en_cmd = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge vga_clock);
    release_reset();
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    int t0;
    en_cmd = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    tp_cmd = 1'b1;
`endif
    t0 = cyc;
    for (int i = 0; i < HT + 20; i++) begin
      step();
      if (tp_cmd && cyc - 1 == t0 + 520 + 2) begin
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 8'hE0)
          $display("FAIL bar4 got r=%0d g=%0d b=%0d expected 7 0 0", vga_red, vga_green, vga_blue);
        else passes++;
      end
    end
    tp_cmd = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_enable_drop();
    test_reset_in_sync();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
